mem_ext_loader: RTL and testbench
=================================

Name: mem_ext_loader

Overview:
- Host-side driver for the CPU's external memory ports. It controls instruction-memory access (addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext), data-memory access (the *_2 set) and the CPU enable input.
- It accepts a 32-bit command/data word stream and carries out four commands: load instruction memory, load data memory, run the CPU for N cycles, and dump a data-memory region back out on a 32-bit output stream.
- It sits between the testbench/UART front-end and the cpu top.

Parameters:
- CNT_W, 14, width of the per-command word count.
- RUN_W, 30, width of the run cycle counter.

Ports:
- clk  input  1  main clock
- arst_n  input  1  asynchronous active-low reset
- in_data  input  32  command/data stream word
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader accepts in_data this cycle
- out_data  output  32  dump stream word
- out_valid  output  1  out_data is valid
- out_ready  input  1  sink accepts out_data
- cpu_enable  output  1  drives cpu enable
- addr_ext  output  64  instruction-memory external byte address
- wen_ext  output  1  instruction-memory external write enable
- ren_ext  output  1  instruction-memory external read enable (tied 0)
- wdata_ext  output  32  instruction-memory write word
- addr_ext_2  output  64  data-memory external byte address
- wen_ext_2  output  1  data-memory external write enable
- ren_ext_2  output  1  data-memory external read enable
- wdata_ext_2  output  64  data-memory write word
- rdata_ext_2  input  64  data-memory read word, valid the cycle after ren_ext_2
- busy  output  1  state is not IDLE
- run_done  output  1  one-cycle pulse when RUN completes

Behaviour:
- Clock and reset: single clock clk. arst_n is asynchronous and active-low.
- Reset values: every output is 0, state is IDLE, all counters are 0. Reset in any state abandons the command; partially loaded words already written stay in memory.
- Handshakes: a beat transfers when valid & ready are high on a rising edge. out_data/out_valid are held stable until out_ready is seen.
- Header word (accepted in IDLE, in_ready=1):
  - [31:30] cmd: 00 LOAD_IMEM, 01 LOAD_DMEM, 10 RUN, 11 DUMP_DMEM.
  - LOAD/DUMP: [29:16] count (words), [15:0] start word index.
  - RUN: [29:0] cycle count.
  - A count of 0 returns to IDLE the next cycle with no memory or enable activity.
- Addressing:
  - Instruction-memory byte address = index<<2.
  - Data-memory byte address = index<<3.
  - Both are zero-extended to 64 bits. The index is 16 bits and wraps 0xFFFF->0.
- IMEM_WR:
  - in_ready=1.
  - Each accepted beat gives, on the next cycle: a one-cycle wen_ext pulse, addr_ext = current address, wdata_ext = the beat.
  - Index increments and the counter decrements. After the last beat's write cycle, go to IDLE.
- DMEM_LO / DMEM_HI:
  - in_ready=1. The low half is accepted first and held, then the high half.
  - The cycle after the high beat: one-cycle wen_ext_2 pulse, wdata_ext_2 = {hi,lo}, addr_ext_2 = current address.
  - Loop until the count is exhausted.
- RUN:
  - in_ready=0. cpu_enable=1 for exactly N consecutive cycles, starting the cycle after the header is accepted.
  - All wen/ren outputs stay 0 during RUN.
  - run_done pulses in the cycle after cpu_enable falls, then go to IDLE.
- DUMP path:
  - DUMP_RD: ren_ext_2=1 for one cycle with addr_ext_2 = current address.
  - DUMP_CAP: capture rdata_ext_2.
  - DUMP_LO: out_data = captured[31:0], out_valid=1 until accepted.
  - DUMP_HI: out_data = captured[63:32], out_valid=1 until accepted.
  - Then either the next DUMP_RD or IDLE. Output throughput is at most 2 beats per 4 cycles.
- in_ready is 0 in RUN and all DUMP states; in_valid there is ignored and not consumed.
- out_valid is 0 except in DUMP_LO/DUMP_HI.
- busy=1 whenever state is not IDLE.
- Between commands, addr_ext/addr_ext_2/wdata outputs hold their last values; enables are 0.

Test Plan:
- Reset, then in_valid=0 -> all outputs 0, in_ready=1, busy=0.
- LOAD_IMEM header 0x0003_0004 (count 3, start 4), then words 0xAAA, 0xBBB, 0xCCC -> three wen_ext pulses at addr_ext 0x10, 0x14, 0x18 with the matching wdata_ext; busy returns to 0.
- LOAD_DMEM header 0x4002_0000 (count 2, start 0), beats 0x1,0x2,0x3,0x4 -> wen_ext_2 writes 0x0000_0002_0000_0001 @0x0 and 0x0000_0004_0000_0003 @0x8.
- RUN header 0x8000_0005 -> cpu_enable high exactly 5 cycles, in_ready=0 throughout, run_done a single pulse after enable falls.
- DUMP_DMEM header 0xC002_0000 with rdata model returning 0xDEAD_BEEF_0123_4567, out_ready held low for 3 cycles -> out_data 0x0123_4567 held stable until accepted, then 0xDEAD_BEEF; 4 output beats total.
- Assert arst_n low mid-LOAD_IMEM after 1 of 3 beats -> outputs 0 immediately; after release a fresh header is accepted and the stale count is not resumed.

Source files
------------

// File: rtl/mem_ext_loader.sv
// Host-side loader: turns a 32-bit command/data word stream into CPU external
// memory writes, bounded CPU run windows and data-memory dumps.
module mem_ext_loader #(
   parameter int CNT_W = 14,
   parameter int RUN_W = 30
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        cpu_enable,
   output logic [63:0] addr_ext,
   output logic        wen_ext,
   output logic        ren_ext,
   output logic [31:0] wdata_ext,
   output logic [63:0] addr_ext_2,
   output logic        wen_ext_2,
   output logic        ren_ext_2,
   output logic [63:0] wdata_ext_2,
   input  logic [63:0] rdata_ext_2,
   output logic        busy,
   output logic        run_done
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_IMEM_WR  = 4'd1,
      S_DMEM_LO  = 4'd2,
      S_DMEM_HI  = 4'd3,
      S_RUN      = 4'd4,
      S_DUMP_RD  = 4'd5,
      S_DUMP_CAP = 4'd6,
      S_DUMP_LO  = 4'd7,
      S_DUMP_HI  = 4'd8
   } state_t;

   localparam logic [1:0]       CMD_IMEM = 2'b00;
   localparam logic [1:0]       CMD_DMEM = 2'b01;
   localparam logic [1:0]       CMD_RUN  = 2'b10;
   localparam logic [1:0]       CMD_DUMP = 2'b11;
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [RUN_W-1:0] RUN_ZERO = {RUN_W{1'b0}};
   localparam logic [RUN_W-1:0] RUN_ONE  = {{(RUN_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      idx_q, idx_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      cap_hi_q, cap_hi_d;
   logic             cpu_enable_q, cpu_enable_d;
   logic             run_done_q, run_done_d;
   logic [63:0]      addr_ext_q, addr_ext_d;
   logic             wen_ext_q, wen_ext_d;
   logic [31:0]      wdata_ext_q, wdata_ext_d;
   logic [63:0]      addr_ext_2_q, addr_ext_2_d;
   logic             wen_ext_2_q, wen_ext_2_d;
   logic             ren_ext_2_q, ren_ext_2_d;
   logic [63:0]      wdata_ext_2_q, wdata_ext_2_d;
   logic [31:0]      out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;

   logic             in_ready_s, in_fire_s, out_fire_s;
   logic [1:0]       hdr_cmd_s;
   logic [CNT_W-1:0] hdr_cnt_s;
   logic [15:0]      hdr_idx_s;
   logic [RUN_W-1:0] hdr_run_s;
   logic [15:0]      idx_nx_s;

   assign hdr_cmd_s  = in_data[31:30];
   assign hdr_cnt_s  = in_data[16 +: CNT_W];
   assign hdr_idx_s  = in_data[15:0];
   assign hdr_run_s  = in_data[RUN_W-1:0];
   assign idx_nx_s   = idx_q + 16'd1;
   // Load states stop taking words once the count is exhausted (final write cycle).
   assign in_ready_s = (state_q == S_IDLE) ||
                       (((state_q == S_IMEM_WR) || (state_q == S_DMEM_LO) ||
                         (state_q == S_DMEM_HI)) && (cnt_q != CNT_ZERO));
   assign in_fire_s  = in_valid & in_ready_s;
   assign out_fire_s = out_valid_q & out_ready;

   // State register and all datapath/output flops.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= CNT_ZERO;
         idx_q         <= 16'd0;
         run_q         <= RUN_ZERO;
         lo_q          <= 32'd0;
         cap_hi_q      <= 32'd0;
         cpu_enable_q  <= 1'b0;
         run_done_q    <= 1'b0;
         addr_ext_q    <= 64'd0;
         wen_ext_q     <= 1'b0;
         wdata_ext_q   <= 32'd0;
         addr_ext_2_q  <= 64'd0;
         wen_ext_2_q   <= 1'b0;
         ren_ext_2_q   <= 1'b0;
         wdata_ext_2_q <= 64'd0;
         out_data_q    <= 32'd0;
         out_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         run_q         <= run_d;
         lo_q          <= lo_d;
         cap_hi_q      <= cap_hi_d;
         cpu_enable_q  <= cpu_enable_d;
         run_done_q    <= run_done_d;
         addr_ext_q    <= addr_ext_d;
         wen_ext_q     <= wen_ext_d;
         wdata_ext_q   <= wdata_ext_d;
         addr_ext_2_q  <= addr_ext_2_d;
         wen_ext_2_q   <= wen_ext_2_d;
         ren_ext_2_q   <= ren_ext_2_d;
         wdata_ext_2_q <= wdata_ext_2_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
      end
   end

   // Next-state and counter logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      run_d    = run_q;
      lo_d     = lo_q;
      cap_hi_d = cap_hi_q;
      case (state_q)
         S_IDLE: begin
            if (in_fire_s) begin
               cnt_d = hdr_cnt_s;
               idx_d = hdr_idx_s;
               run_d = hdr_run_s;
               case (hdr_cmd_s)
                  CMD_IMEM: state_d = S_IMEM_WR;
                  CMD_DMEM: state_d = S_DMEM_LO;
                  CMD_RUN:  state_d = S_RUN;
                  // an empty dump spends its one busy cycle in the idle load state
                  CMD_DUMP: state_d = (hdr_cnt_s == CNT_ZERO) ? S_IMEM_WR : S_DUMP_RD;
                  default:  state_d = S_IDLE;
               endcase
            end else begin
               state_d = S_IDLE;
            end
         end
         S_IMEM_WR: begin
            if (cnt_q == CNT_ZERO) begin
               state_d = S_IDLE;
            end else if (in_fire_s) begin
               cnt_d = cnt_q - CNT_ONE;
               idx_d = idx_nx_s;
            end else begin
               state_d = S_IMEM_WR;
            end
         end
         S_DMEM_LO: begin
            if (cnt_q == CNT_ZERO) begin
               state_d = S_IDLE;
            end else if (in_fire_s) begin
               lo_d    = in_data;
               state_d = S_DMEM_HI;
            end else begin
               state_d = S_DMEM_LO;
            end
         end
         S_DMEM_HI: begin
            if (in_fire_s) begin
               cnt_d   = cnt_q - CNT_ONE;
               idx_d   = idx_nx_s;
               state_d = S_DMEM_LO;
            end else begin
               state_d = S_DMEM_HI;
            end
         end
         S_RUN: begin
            if (run_q == RUN_ZERO) begin
               state_d = S_IDLE;
            end else begin
               run_d = run_q - RUN_ONE;
            end
         end
         S_DUMP_RD:  state_d = S_DUMP_CAP;
         S_DUMP_CAP: begin
            cap_hi_d = rdata_ext_2[63:32];
            state_d  = S_DUMP_LO;
         end
         S_DUMP_LO: begin
            if (out_fire_s) begin
               state_d = S_DUMP_HI;
            end else begin
               state_d = S_DUMP_LO;
            end
         end
         S_DUMP_HI: begin
            if (out_fire_s) begin
               cnt_d   = cnt_q - CNT_ONE;
               idx_d   = idx_nx_s;
               state_d = (cnt_q == CNT_ONE) ? S_IDLE : S_DUMP_RD;
            end else begin
               state_d = S_DUMP_HI;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Registered output values for the next cycle; addresses and data hold between uses.
   always_comb begin
      cpu_enable_d  = 1'b0;
      run_done_d    = 1'b0;
      wen_ext_d     = 1'b0;
      wen_ext_2_d   = 1'b0;
      ren_ext_2_d   = 1'b0;
      out_valid_d   = 1'b0;
      addr_ext_d    = addr_ext_q;
      wdata_ext_d   = wdata_ext_q;
      addr_ext_2_d  = addr_ext_2_q;
      wdata_ext_2_d = wdata_ext_2_q;
      out_data_d    = out_data_q;
      case (state_q)
         S_IDLE: begin
            if (in_fire_s && (hdr_cmd_s == CMD_RUN)) begin
               cpu_enable_d = (hdr_run_s != RUN_ZERO);
            end else if (in_fire_s && (hdr_cmd_s == CMD_DUMP) && (hdr_cnt_s != CNT_ZERO)) begin
               ren_ext_2_d  = 1'b1;
               addr_ext_2_d = {45'd0, hdr_idx_s, 3'd0};
            end else begin
               cpu_enable_d = 1'b0;
            end
         end
         S_IMEM_WR: begin
            if (in_fire_s) begin
               wen_ext_d   = 1'b1;
               addr_ext_d  = {46'd0, idx_q, 2'd0};
               wdata_ext_d = in_data;
            end else begin
               wen_ext_d = 1'b0;
            end
         end
         S_DMEM_HI: begin
            if (in_fire_s) begin
               wen_ext_2_d   = 1'b1;
               addr_ext_2_d  = {45'd0, idx_q, 3'd0};
               wdata_ext_2_d = {in_data, lo_q};
            end else begin
               wen_ext_2_d = 1'b0;
            end
         end
         S_RUN: begin
            if (run_q != RUN_ZERO) begin
               cpu_enable_d = (run_q != RUN_ONE);
               run_done_d   = (run_q == RUN_ONE);
            end else begin
               cpu_enable_d = 1'b0;
            end
         end
         S_DUMP_CAP: begin
            out_valid_d = 1'b1;
            out_data_d  = rdata_ext_2[31:0];
         end
         S_DUMP_LO: begin
            out_valid_d = 1'b1;
            if (out_fire_s) begin
               out_data_d = cap_hi_q;
            end else begin
               out_data_d = out_data_q;
            end
         end
         S_DUMP_HI: begin
            if (out_fire_s) begin
               out_valid_d = 1'b0;
               if (cnt_q != CNT_ONE) begin
                  ren_ext_2_d  = 1'b1;
                  addr_ext_2_d = {45'd0, idx_nx_s, 3'd0};
               end else begin
                  ren_ext_2_d = 1'b0;
               end
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: out_valid_d = 1'b0;
      endcase
   end

   assign in_ready    = in_ready_s;
   assign busy        = (state_q != S_IDLE);
   assign ren_ext     = 1'b0;
   assign cpu_enable  = cpu_enable_q;
   assign run_done    = run_done_q;
   assign addr_ext    = addr_ext_q;
   assign wen_ext     = wen_ext_q;
   assign wdata_ext   = wdata_ext_q;
   assign addr_ext_2  = addr_ext_2_q;
   assign wen_ext_2   = wen_ext_2_q;
   assign ren_ext_2   = ren_ext_2_q;
   assign wdata_ext_2 = wdata_ext_2_q;
   assign out_data    = out_data_q;
   assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_mem_ext_loader.sv
// Bench for mem_ext_loader: directed literal cases plus random command streams
// checked against transaction queues, a data-memory model and a run-window model.
module tb_mem_ext_loader;

   localparam logic [63:0] DEF_WORD = 64'hDEAD_BEEF_0123_4567;

   logic        clk = 1'b0;
   logic        arst_n = 1'b1;
   logic [31:0] in_data = 32'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        cpu_enable;
   logic [63:0] addr_ext;
   logic        wen_ext;
   logic        ren_ext;
   logic [31:0] wdata_ext;
   logic [63:0] addr_ext_2;
   logic        wen_ext_2;
   logic        ren_ext_2;
   logic [63:0] wdata_ext_2;
   logic [63:0] rdata_ext_2;
   logic        busy;
   logic        run_done;

   typedef struct packed { logic [63:0] addr; logic [63:0] data; } wr_t;

   wr_t         imem_q[$];
   wr_t         dmem_q[$];
   logic [31:0] dump_q[$];
   logic [63:0] model_mem[logic [15:0]];
   logic [63:0] emu_mem[logic [63:0]];

   int  total = 0;
   int  bad = 0;
   int  cyc = 0;
   int  gap_max = 0;
   int  hold_low = 0;
   bit  rnd_ready = 1'b0;
   bit  cur_hdr = 1'b0;
   int  en_cnt = 0;
   int  done_cnt = 0;
   int  beats = 0;

   always #5 clk = ~clk;

   mem_ext_loader dut (
      .clk(clk), .arst_n(arst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .cpu_enable(cpu_enable),
      .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
      .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
      .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2), .busy(busy), .run_done(run_done)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] mget(input logic [15:0] ix);
      return model_mem.exists(ix) ? model_mem[ix] : DEF_WORD;
   endfunction

   task automatic send(input logic [31:0] w, input bit is_hdr);
      int n;
      repeat ($urandom_range(0, gap_max)) begin
         @(posedge clk); #1;
      end
      in_data = w; in_valid = 1'b1; cur_hdr = is_hdr;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 400) begin
            total++; bad++;
            $display("FAIL send_timeout: word 0x%0h not accepted", w);
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0; cur_hdr = 1'b0; in_data = $urandom;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((imem_q.size() != 0 || dmem_q.size() != 0 || dump_q.size() != 0 || busy) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (n >= 2000) begin
         bad++;
         $display("FAIL %s_idle_timeout: busy=%0b pending imem=%0d dmem=%0d dump=%0d",
                  name, busy, imem_q.size(), dmem_q.size(), dump_q.size());
      end
      chk({name, "_busy"}, {63'd0, busy}, 64'd0);
      chk({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
   endtask

   // Memory emulation: writes land, reads answer the cycle after ren_ext_2.
   initial begin : emu
      bit          rd_req;
      logic [63:0] rd_addr;
      rdata_ext_2 = 64'd0;
      forever begin
         @(negedge clk);
         rd_req  = ren_ext_2 && arst_n;
         rd_addr = addr_ext_2;
         if (wen_ext_2 && arst_n) emu_mem[addr_ext_2] = wdata_ext_2;
         @(posedge clk); #1;
         if (rd_req) rdata_ext_2 = emu_mem.exists(rd_addr) ? emu_mem[rd_addr] : DEF_WORD;
         else        rdata_ext_2 = {$urandom, $urandom};
      end
   end

   initial begin : sink
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (hold_low > 0) begin
            out_ready = 1'b0;
            if (out_valid) hold_low--;
         end else begin
            out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
      end
   end

   // Compare process: mid-cycle checks of every output against the model.
   initial begin : monitor
      bit run_act;
      int run_start, run_n;
      bit en_exp, done_exp;
      wr_t e;
      run_act = 1'b0; run_start = 0; run_n = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!arst_n) begin
            run_act = 1'b0;
            continue;
         end
         en_exp   = run_act && (cyc >= run_start) && (cyc < run_start + run_n);
         done_exp = run_act && (run_n > 0) && (cyc == run_start + run_n);
         chk("cpu_enable", {63'd0, cpu_enable}, {63'd0, en_exp});
         chk("run_done", {63'd0, run_done}, {63'd0, done_exp});
         chk("ren_ext", {63'd0, ren_ext}, 64'd0);
         if (run_act && (cyc >= run_start) && (cyc <= run_start + run_n)) begin
            chk("run_in_ready", {63'd0, in_ready}, 64'd0);
            chk("run_ren_ext_2", {63'd0, ren_ext_2}, 64'd0);
         end
         if (run_act && (cyc > run_start + run_n)) run_act = 1'b0;
         if (cpu_enable) en_cnt++;
         if (run_done) done_cnt++;
         if (in_valid && in_ready && cur_hdr && (in_data[31:30] == 2'b10)) begin
            run_act = 1'b1; run_start = cyc + 1; run_n = int'(in_data[29:0]);
         end
         if (wen_ext) begin
            if (imem_q.size() == 0) begin
               total++; bad++;
               $display("FAIL imem_unexpected: wen_ext addr 0x%0h data 0x%0h expected none", addr_ext, wdata_ext);
            end else begin
               e = imem_q.pop_front();
               chk("imem_addr", addr_ext, e.addr);
               chk("imem_data", {32'd0, wdata_ext}, e.data);
            end
         end
         if (wen_ext_2) begin
            if (dmem_q.size() == 0) begin
               total++; bad++;
               $display("FAIL dmem_unexpected: wen_ext_2 addr 0x%0h data 0x%0h expected none", addr_ext_2, wdata_ext_2);
            end else begin
               e = dmem_q.pop_front();
               chk("dmem_addr", addr_ext_2, e.addr);
               chk("dmem_data", wdata_ext_2, e.data);
            end
         end
         if (out_valid) begin
            if (dump_q.size() == 0) begin
               total++; bad++;
               $display("FAIL dump_unexpected: out_data 0x%0h expected no beat", out_data);
            end else begin
               chk("dump_data", {32'd0, out_data}, {32'd0, dump_q[0]});
               if (out_ready) begin
                  void'(dump_q.pop_front());
                  beats++;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [1:0]  cmd;
      int          cnt, runn;
      logic [15:0] start, ix;
      logic [31:0] w, lo, hi;
      logic [63:0] d;

      #2 arst_n = 1'b0;
      #20 arst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_enables", {58'd0, wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, run_done}, 64'd0);
      chk("rst_addr", addr_ext | addr_ext_2, 64'd0);
      chk("rst_wdata", wdata_ext_2 | {32'd0, wdata_ext}, 64'd0);
      chk("rst_out", {31'd0, out_valid, out_data}, 64'd0);

      imem_q.push_back('{64'h10, 64'hAAA});
      imem_q.push_back('{64'h14, 64'hBBB});
      imem_q.push_back('{64'h18, 64'hCCC});
      send(32'h0003_0004, 1'b1);
      send(32'h0000_0AAA, 1'b0);
      send(32'h0000_0BBB, 1'b0);
      send(32'h0000_0CCC, 1'b0);
      wait_idle("imem");

      beats = 0; hold_low = 3;
      dump_q.push_back(32'h0123_4567); dump_q.push_back(32'hDEAD_BEEF);
      dump_q.push_back(32'h0123_4567); dump_q.push_back(32'hDEAD_BEEF);
      send(32'hC002_0000, 1'b1);
      wait_idle("dump");
      chk("dump_beats", 64'(beats), 64'd4);

      model_mem[16'd0] = 64'h0000_0002_0000_0001;
      model_mem[16'd1] = 64'h0000_0004_0000_0003;
      dmem_q.push_back('{64'h0, 64'h0000_0002_0000_0001});
      dmem_q.push_back('{64'h8, 64'h0000_0004_0000_0003});
      send(32'h4002_0000, 1'b1);
      send(32'h1, 1'b0); send(32'h2, 1'b0); send(32'h3, 1'b0); send(32'h4, 1'b0);
      wait_idle("dmem");

      en_cnt = 0; done_cnt = 0;
      send(32'h8000_0005, 1'b1);
      wait_idle("run");
      chk("run_en_cycles", 64'(en_cnt), 64'd5);
      chk("run_done_pulses", 64'(done_cnt), 64'd1);

      imem_q.push_back('{64'h14, 64'h111});
      send(32'h0003_0005, 1'b1);
      send(32'h0000_0111, 1'b0);
      @(negedge clk);
      @(posedge clk); #3;
      arst_n = 1'b0;
      #1;
      chk("mid_rst_wen_addr", addr_ext | {63'd0, wen_ext}, 64'd0);
      chk("mid_rst_wdata", {32'd0, wdata_ext}, 64'd0);
      chk("mid_rst_busy_ready", {62'd0, busy, in_ready}, 64'd1);
      imem_q.delete();
      @(negedge clk); #1;
      arst_n = 1'b1;
      @(posedge clk); #1;
      imem_q.push_back('{64'h80, 64'h5A5A});
      send(32'h0001_0020, 1'b1);
      send(32'h0000_5A5A, 1'b0);
      wait_idle("post_rst");

      gap_max = 2; rnd_ready = 1'b1;
      for (int it = 0; it < 40; it++) begin
         cmd   = 2'($urandom_range(0, 3));
         cnt   = $urandom_range(0, 4);
         start = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom_range(0, 10));
         runn  = $urandom_range(0, 6);
         case (cmd)
            2'b00: begin
               send({2'b00, 14'(cnt), start}, 1'b1);
               for (int i = 0; i < cnt; i++) begin
                  ix = start + 16'(i);
                  w  = $urandom;
                  imem_q.push_back('{64'(ix) * 64'd4, {32'd0, w}});
                  send(w, 1'b0);
               end
            end
            2'b01: begin
               send({2'b01, 14'(cnt), start}, 1'b1);
               for (int i = 0; i < cnt; i++) begin
                  ix = start + 16'(i);
                  lo = $urandom; hi = $urandom;
                  d  = {hi, lo};
                  model_mem[ix] = d;
                  dmem_q.push_back('{64'(ix) * 64'd8, d});
                  send(lo, 1'b0);
                  send(hi, 1'b0);
               end
            end
            2'b10: send({2'b10, 30'(runn)}, 1'b1);
            default: begin
               for (int i = 0; i < cnt; i++) begin
                  d = mget(start + 16'(i));
                  dump_q.push_back(d[31:0]);
                  dump_q.push_back(d[63:32]);
               end
               send({2'b11, 14'(cnt), start}, 1'b1);
            end
         endcase
      end
      wait_idle("random");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
